// File: rtl/gps_ack_pkg.sv
// Shared types and constants for the GPS acquisition scheduler and its metric datapath.
package gps_ack_pkg;
  localparam int NUM_SAT  = 8;
  localparam int METRIC_W = 15;

  typedef enum logic [2:0] {IDLE, START, RUN, SCAN, REPORT} sched_state_t;

  typedef struct packed {
    logic [METRIC_W-1:0] metric;
    logic [9:0]          code_phase;
    logic [15:0]         doppler;
  } peak_t;
endpackage

// File: rtl/gps_ack_metric.sv
// Correlation metric |I - bias| + |Q - bias| for one channel, saturated to 14 bits of magnitude.
module gps_ack_metric import gps_ack_pkg::*; #(
  parameter int SAMPLE_NUM = 16384
) (
  input  logic [13:0]         i,
  input  logic [13:0]         q,
  output logic [METRIC_W-1:0] metric
);
  localparam logic signed [14:0] BIAS = 15'(SAMPLE_NUM / 2);

  logic signed [14:0] di, dq;
  logic [14:0]        ai, aq;
  logic [15:0]        sum;

  always_comb begin
    di     = $signed({1'b0, i}) - BIAS;
    dq     = $signed({1'b0, q}) - BIAS;
    ai     = di[14] ? $unsigned(-di) : $unsigned(di);
    aq     = dq[14] ? $unsigned(-dq) : $unsigned(dq);
    sum    = {1'b0, ai} + {1'b0, aq};
    metric = (sum > 16'd16383) ? 15'd16383 : sum[14:0];
  end
endmodule

// File: rtl/gps_ack_sched.sv
// Search sequencer and per-satellite peak picker for the GPS acquisition engine.
//   state  | meaning
//   IDLE   | waiting for search_req
//   START  | ack_start pulse to the engine
//   RUN    | waiting for a corr_complete edge or end of search
//   SCAN   | scoring snapshot, one channel per cycle
//   REPORT | streaming one result per satellite
module gps_ack_sched #(
  parameter int          SAMPLE_NUM = 16384,
  parameter int          NUM_SAT    = 8,
  parameter logic [14:0] THRESH     = 15'd2400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  search_req,
  output logic                  search_busy,
  output logic                  ack_start,
  input  logic                  corr_complete,
  input  logic                  search_complete,
  input  logic [9:0]            code_phase,
  input  logic signed [15:0]    doppler_omega,
  input  logic [6*NUM_SAT-1:0]  sat_ids,
  input  logic [14*NUM_SAT-1:0] integ_i,
  input  logic [14*NUM_SAT-1:0] integ_q,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [5:0]            res_sat,
  output logic                  res_found,
  output logic [9:0]            res_code_phase,
  output logic [15:0]           res_doppler,
  output logic [14:0]           res_metric,
  output logic                  overrun
);
  import gps_ack_pkg::*;

  localparam int KW = (NUM_SAT > 1) ? $clog2(NUM_SAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SAT - 1);

  sched_state_t        state;
  logic [KW-1:0]       k;
  logic                cc_prev, sc_prev, pending;
  logic                cc_edge, sc_edge;
  logic [13:0]         snap_i [NUM_SAT];
  logic [13:0]         snap_q [NUM_SAT];
  logic [9:0]          snap_phase;
  logic [15:0]         snap_dop;
  logic [5:0]          sat_q  [NUM_SAT];
  peak_t               peak   [NUM_SAT];
  logic [METRIC_W-1:0] metric;
  logic [KW-1:0]       k_next;

  assign cc_edge = corr_complete & ~cc_prev;
  assign sc_edge = search_complete & ~sc_prev;
  assign k_next  = KW'(k + 1'b1);

  gps_ack_metric #(.SAMPLE_NUM(SAMPLE_NUM)) u_metric (
    .i      (snap_i[k]),
    .q      (snap_q[k]),
    .metric (metric)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      k              <= '0;
      cc_prev        <= 1'b0;
      sc_prev        <= 1'b0;
      pending        <= 1'b0;
      ack_start      <= 1'b0;
      search_busy    <= 1'b0;
      overrun        <= 1'b0;
      res_valid      <= 1'b0;
      res_sat        <= '0;
      res_found      <= 1'b0;
      res_code_phase <= '0;
      res_doppler    <= '0;
      res_metric     <= '0;
      snap_phase     <= '0;
      snap_dop       <= '0;
      for (int c = 0; c < NUM_SAT; c++) begin
        snap_i[c] <= '0;
        snap_q[c] <= '0;
        sat_q[c]  <= '0;
        peak[c]   <= '0;
      end
    end else begin
      cc_prev   <= corr_complete;
      sc_prev   <= search_complete;
      ack_start <= 1'b0;
      case (state)
        IDLE: if (search_req) begin
          state       <= START;
          ack_start   <= 1'b1;
          search_busy <= 1'b1;
          overrun     <= 1'b0;
          pending     <= 1'b0;
          k           <= '0;
          for (int c = 0; c < NUM_SAT; c++) begin
            peak[c]  <= '0;
            sat_q[c] <= sat_ids[6*c +: 6];
          end
        end
        START: state <= RUN;
        RUN: begin
          if (sc_edge) pending <= 1'b1;
          // A snapshot edge wins over a coincident end-of-search edge.
          if (cc_edge) begin
            for (int c = 0; c < NUM_SAT; c++) begin
              snap_i[c] <= integ_i[14*c +: 14];
              snap_q[c] <= integ_q[14*c +: 14];
            end
            snap_phase <= code_phase;
            snap_dop   <= doppler_omega;
            k          <= '0;
            state      <= SCAN;
          end else if (pending || sc_edge) begin
            k              <= '0;
            state          <= REPORT;
            res_valid      <= 1'b1;
            res_sat        <= sat_q[0];
            res_metric     <= peak[0].metric;
            res_found      <= peak[0].metric >= THRESH;
            res_code_phase <= peak[0].code_phase;
            res_doppler    <= peak[0].doppler;
          end
        end
        SCAN: begin
          if (metric > peak[k].metric)
            peak[k] <= '{metric: metric, code_phase: snap_phase, doppler: snap_dop};
          if (cc_edge) overrun <= 1'b1;
          if (sc_edge) pending <= 1'b1;
          if (k == K_LAST) begin
            k <= '0;
            if (pending || sc_edge) begin
              state          <= REPORT;
              res_valid      <= 1'b1;
              res_sat        <= sat_q[0];
              res_metric     <= peak[0].metric;
              res_found      <= peak[0].metric >= THRESH;
              res_code_phase <= peak[0].code_phase;
              res_doppler    <= peak[0].doppler;
            end else begin
              state <= RUN;
            end
          end else begin
            k <= k_next;
          end
        end
        REPORT: if (res_ready) begin
          if (k == K_LAST) begin
            state       <= IDLE;
            res_valid   <= 1'b0;
            search_busy <= 1'b0;
            pending     <= 1'b0;
            k           <= '0;
          end else begin
            k              <= k_next;
            res_sat        <= sat_q[k_next];
            res_metric     <= peak[k_next].metric;
            res_found      <= peak[k_next].metric >= THRESH;
            res_code_phase <= peak[k_next].code_phase;
            res_doppler    <= peak[k_next].doppler;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
